// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy/threshold flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read data.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] FULL_LVL = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_LVL   = (PTR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] AE_LVL   = (PTR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    wr_ptr;
    logic [PTR_WIDTH:0]    rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // A flush takes priority over any transfer in the same cycle.
    assign wr_ok = w_en && !full  && !clr;
    assign rd_ok = r_en && !empty && !clr;

    assign full         = (count == FULL_LVL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= w_en && full;
            underflow <= r_en && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr[PTR_WIDTH-1:0]];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (clr) begin
            data_out <= '0;
        end else if (rd_ok) begin
            data_out <= mem[rd_ptr[PTR_WIDTH-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (default standard-read build).
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       w_en;
    logic [7:0] data_in;
    logic       r_en;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_flags #(
        .DATA_WIDTH(8),
        .PTR_WIDTH (3),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .w_en        (w_en),
        .data_in     (data_in),
        .r_en        (r_en),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
        w_en    = w;
        data_in = d;
        r_en    = r;
        clr     = c;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        clr  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b1;
        clr     = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = 8'h00;

        // Asynchronous reset between clock edges
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst_count", 16'(count), 16'd0);
        checkOutput("rst_empty", 16'(empty), 16'd1);
        checkOutput("rst_ae", 16'(almost_empty), 16'd1);
        checkOutput("rst_full", 16'(full), 16'd0);
        checkOutput("rst_af", 16'(almost_full), 16'd0);
        checkOutput("rst_dout", 16'(data_out), 16'd0);
        checkOutput("rst_ovf", 16'(overflow), 16'd0);
        checkOutput("rst_unf", 16'(underflow), 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("fill_count", 16'(count), 16'(i));
            checkOutput("fill_ae", 16'(almost_empty), 16'(i <= 2));
            checkOutput("fill_af", 16'(almost_full), 16'(i >= 6));
            checkOutput("fill_full", 16'(full), 16'(i == 8));
            checkOutput("fill_empty", 16'(empty), 16'd0);
        end
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("ovf_pulse", 16'(overflow), 16'd1);
        checkOutput("ovf_count", 16'(count), 16'd8);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ovf_clear", 16'(overflow), 16'd0);

        // Drain: data appears on the edge that accepts the read
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain_data", 16'(data_out), 16'(i));
            checkOutput("drain_count", 16'(count), 16'(8 - i));
        end
        checkOutput("drain_empty", 16'(empty), 16'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("unf_pulse", 16'(underflow), 16'd1);
        checkOutput("unf_count", 16'(count), 16'd0);
        checkOutput("unf_hold", 16'(data_out), 16'h08);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("unf_clear", 16'(underflow), 16'd0);

        // Simultaneous at empty: write wins, read rejected
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
        checkOutput("bnd0_count", 16'(count), 16'd1);
        checkOutput("bnd0_unf", 16'(underflow), 16'd1);
        checkOutput("bnd0_dout", 16'(data_out), 16'h08);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 8'(8'h34 + i), 1'b0, 1'b0);
        end
        checkOutput("bnd8_full", 16'(full), 16'd1);
        // Simultaneous at full: read wins, write dropped
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        checkOutput("bnd8_count", 16'(count), 16'd7);
        checkOutput("bnd8_ovf", 16'(overflow), 16'd1);
        checkOutput("bnd8_dout", 16'(data_out), 16'h33);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("bnd_drain", 16'(data_out), 16'(8'h34 + i));
        end
        checkOutput("bnd_empty", 16'(empty), 16'd1);

        // Steady-state streaming at count 4 across pointer wrap
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 8'(8'h44 + k), 1'b1, 1'b0);
            checkOutput("wrap_data", 16'(data_out), 16'(8'h40 + k));
            checkOutput("wrap_count", 16'(count), 16'd4);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("wrap_tail", 16'(data_out), 16'(8'h54 + i));
        end

        // Flush at count 5 with a concurrent write
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        end
        checkOutput("pre_clr_count", 16'(count), 16'd5);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
        checkOutput("clr_count", 16'(count), 16'd0);
        checkOutput("clr_empty", 16'(empty), 16'd1);
        checkOutput("clr_ovf", 16'(overflow), 16'd0);
        checkOutput("clr_dout", 16'(data_out), 16'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("clr_unf", 16'(underflow), 16'd0);
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_clr_d0", 16'(data_out), 16'hB1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_clr_d1", 16'(data_out), 16'hB2);
        checkOutput("post_clr_cnt", 16'(count), 16'd0);

        // Reset in the middle of operation discards contents
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_count", 16'(count), 16'd0);
        checkOutput("mid_rst_empty", 16'(empty), 16'd1);
        checkOutput("mid_rst_dout", 16'(data_out), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hD2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("after_rst_d0", 16'(data_out), 16'hD1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("after_rst_d1", 16'(data_out), 16'hD2);
        checkOutput("after_rst_cnt", 16'(count), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
